// File: rtl/traffic_lamp_guard.sv
// traffic_lamp_guard: registered safety stage between the phase sequencer and
// the lamp pins. Bad samples (a non-one-hot group, or both reds off) are
// replaced by all-red. A persistent bad condition latches a fault with
// flashing amber until a qualified clear, followed by an all-red hold.
// Optional build macro: TRAFFIC_GUARD_FAULT_CNT_EN enables the saturating
// fault-entry counter on fault_cnt. Without it fault_cnt is tied to zero.
module traffic_lamp_guard #(
  parameter int FAULT_CYC  = 2,
  parameter int FLASH_HALF = 50_000_000,
  parameter int ALLRED_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] lamp_in,
  input  logic       clr_fault,
  output logic [5:0] lamps,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam int BW = $clog2(FAULT_CYC + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int RW = (ALLRED_CYC > 1) ? $clog2(ALLRED_CYC) : 1;

  localparam logic [BW-1:0] BAD_LAST   = BW'(FAULT_CYC - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [RW-1:0] HOLD_INIT  = RW'(ALLRED_CYC - 1);
  localparam logic [5:0]    ALL_RED    = 6'b001001;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
  logic [1:0]      cause_acc_q, cause_acc_d;
  logic [RW-1:0]   hold_q, hold_d;
  logic [FW-1:0]   flash_cnt_q, flash_cnt_d;
  logic            flash_q, flash_d;
  logic [5:0]      lamps_q, lamps_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;

  logic            invalid;
  logic            conflict;
  logic            bad;
  logic [1:0]      cause;
  logic            enter_fault;

  function automatic logic onehot3(input logic [2:0] g);
    return (g == 3'b001) || (g == 3'b010) || (g == 3'b100);
  endfunction

  assign invalid     = !onehot3(lamp_in[5:3]) || !onehot3(lamp_in[2:0]);
  assign conflict    = !lamp_in[3] && !lamp_in[0];
  assign bad         = invalid || conflict;
  assign cause       = {conflict, invalid};
  // The bad sample that completes the persistence window, outside FAULT.
  assign enter_fault = (state_q != ST_FAULT) && bad && (bad_cnt_q == BAD_LAST);

  // Next-state, lamp drive and fault bookkeeping.
  always_comb begin
    state_d      = state_q;
    bad_cnt_d    = bad_cnt_q;
    cause_acc_d  = cause_acc_q;
    hold_d       = hold_q;
    flash_cnt_d  = flash_cnt_q;
    flash_d      = flash_q;
    lamps_d      = lamps_q;
    fault_code_d = fault_code_q;

    case (state_q)
      ST_FAULT: begin
        bad_cnt_d   = '0;
        cause_acc_d = '0;
        if (clr_fault && !bad) begin
          // A clear is honoured only together with a good sample.
          state_d      = ST_RECOVER;
          hold_d       = HOLD_INIT;
          lamps_d      = ALL_RED;
          fault_code_d = 2'b00;
        end else begin
          if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = '0;
            flash_d     = ~flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          lamps_d = {1'b0, flash_d, 2'b00, flash_d, 1'b0};
        end
      end
      default: begin
        // RUN and RECOVER share the bad-sample qualification.
        if (bad) begin
          bad_cnt_d   = bad_cnt_q + 1'b1;
          cause_acc_d = cause_acc_q | cause;
          lamps_d     = ALL_RED;
        end else begin
          bad_cnt_d   = '0;
          cause_acc_d = '0;
          lamps_d     = lamp_in;
        end
        if (state_q == ST_RECOVER) begin
          if (hold_q == '0) begin
            state_d = ST_RUN;
          end else begin
            hold_d  = hold_q - 1'b1;
            lamps_d = ALL_RED;
          end
        end
        // Fault entry overrides both pass-through and the exit to RUN.
        if (enter_fault) begin
          state_d      = ST_FAULT;
          bad_cnt_d    = '0;
          cause_acc_d  = '0;
          fault_code_d = cause_acc_q | cause;
          flash_d      = 1'b1;
          flash_cnt_d  = '0;
          lamps_d      = 6'b010010;
        end
      end
    endcase

    fault_d = (state_d == ST_FAULT);
  end

  // State and registered outputs; reset lands in RECOVER with a full all-red hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RECOVER;
      bad_cnt_q    <= '0;
      cause_acc_q  <= '0;
      hold_q       <= HOLD_INIT;
      flash_cnt_q  <= '0;
      flash_q      <= 1'b1;
      lamps_q      <= ALL_RED;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      bad_cnt_q    <= bad_cnt_d;
      cause_acc_q  <= cause_acc_d;
      hold_q       <= hold_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_q      <= flash_d;
      lamps_q      <= lamps_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign lamps      = lamps_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

`ifdef TRAFFIC_GUARD_FAULT_CNT_EN
  logic [7:0] fault_cnt_q, fault_cnt_d;

  // Saturating count of fault entries, cleared only by reset.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (enter_fault && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_d = fault_cnt_q + 8'd1;
    end
  end

  // Fault-entry counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= 8'd0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign fault_cnt = fault_cnt_q;
`else
  assign fault_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_lamp_guard.sv
// Bench for traffic_lamp_guard with FAULT_CYC=2, FLASH_HALF=4, ALLRED_CYC=3.
module tb_traffic_lamp_guard;

  logic       clk;
  logic       rst;
  logic [5:0] lamp_in;
  logic       clr_fault;
  logic [5:0] lamps;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_cnt;

`ifdef TRAFFIC_GUARD_FAULT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  traffic_lamp_guard #(
    .FAULT_CYC (2),
    .FLASH_HALF(4),
    .ALLRED_CYC(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lamp_in   (lamp_in),
    .clr_fault (clr_fault),
    .lamps     (lamps),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_cnt (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] lamp_in;
    logic       clr;
    logic [5:0] lamps;
    logic       fault;
    logic [1:0] code;
  } vec_t;

  typedef struct {
    logic [5:0] lamps;
    logic       fault;
    logic [1:0] code;
    logic [7:0] cnt;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;
  int entries = 0;

  function automatic logic [7:0] exp_cnt(input int e);
    if (!CNT_EN) return 8'd0;
    return (e > 255) ? 8'd255 : 8'(e);
  endfunction

  task automatic add(input logic [5:0] li, input logic c, input logic [5:0] el,
                     input logic ef, input logic [1:0] ec);
    vec_t v;
    v.lamp_in = li; v.clr = c; v.lamps = el; v.fault = ef; v.code = ec;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] el, input logic ef,
                       input logic [1:0] ec, input logic [7:0] ecnt);
    n_vec++;
    if (lamps !== el || fault !== ef || fault_code !== ec || fault_cnt !== ecnt) begin
      n_miss++;
      $display("FAIL %s: got lamps=%b fault=%b code=%b cnt=%0d, expected lamps=%b fault=%b code=%b cnt=%0d",
               name, lamps, fault, fault_code, fault_cnt, el, ef, ec, ecnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic prev_fault;

    rst       = 1'b1;
    lamp_in   = 6'b100001;
    clr_fault = 1'b0;
    #2;
    check("reset_held", 6'b001001, 1'b0, 2'b00, 8'd0);
    rst = 1'b0;
    #1;
    check("reset_release", 6'b001001, 1'b0, 2'b00, 8'd0);

    // Power-up hold, then pass-through.
    add(6'b100001, 0, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b100001, 0, 2'b00);
    add(6'b100001, 0, 6'b100001, 0, 2'b00);
    // Single-cycle conflict glitch.
    add(6'b100100, 0, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b100001, 0, 2'b00);
    add(6'b010001, 0, 6'b010001, 0, 2'b00);
    // Persistent conflict -> fault, flash 4 on / 4 off.
    add(6'b100100, 0, 6'b001001, 0, 2'b00);
    for (int k = 0; k < 4; k++) add(6'b100100, 0, 6'b010010, 1, 2'b10);
    for (int k = 0; k < 4; k++) add(6'b100100, 0, 6'b000000, 1, 2'b10);
    add(6'b100100, 0, 6'b010010, 1, 2'b10);
    // Clear with a bad sample is ignored; clear with a good sample recovers.
    add(6'b110001, 1, 6'b010010, 1, 2'b10);
    add(6'b001001, 1, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b100001, 0, 2'b00);
    add(6'b100001, 0, 6'b100001, 0, 2'b00);
    // Conflict then invalid accumulate to code 11.
    add(6'b100100, 0, 6'b001001, 0, 2'b00);
    add(6'b110001, 0, 6'b010010, 1, 2'b11);
    add(6'b100001, 1, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b100001, 0, 2'b00);
    // All-dark input is both invalid and conflicting.
    add(6'b000000, 0, 6'b001001, 0, 2'b00);
    add(6'b000000, 0, 6'b010010, 1, 2'b11);
    // Fault entry on the same edge the RECOVER hold would expire.
    add(6'b001001, 1, 6'b001001, 0, 2'b00);
    add(6'b100001, 0, 6'b001001, 0, 2'b00);
    add(6'b100100, 0, 6'b001001, 0, 2'b00);
    add(6'b100100, 0, 6'b010010, 1, 2'b10);

    prev_fault = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      lamp_in   = vt[i].lamp_in;
      clr_fault = vt[i].clr;
      if (vt[i].fault && !prev_fault) entries++;
      prev_fault = vt[i].fault;
      sb.push_back('{lamps: vt[i].lamps, fault: vt[i].fault, code: vt[i].code,
                     cnt: exp_cnt(entries)});
      step();
      e = sb.pop_front();
      check($sformatf("vec%0d", i), e.lamps, e.fault, e.code, e.cnt);
    end

    // Stay in FAULT a little, then reset asynchronously mid-flash.
    lamp_in   = 6'b100100;
    clr_fault = 1'b0;
    step();
    check("fault_hold1", 6'b010010, 1'b1, 2'b10, exp_cnt(entries));
    step();
    check("fault_hold2", 6'b010010, 1'b1, 2'b10, exp_cnt(entries));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 6'b001001, 1'b0, 2'b00, 8'd0);
    step();
    check("reset_over_edge", 6'b001001, 1'b0, 2'b00, 8'd0);
    #2;
    rst     = 1'b0;
    entries = 0;
    step();

    // Repeated fault entries for the counter.
    for (int k = 0; k < 300; k++) begin
      lamp_in   = 6'b100100;
      clr_fault = 1'b0;
      step();
      step();
      entries++;
      if (k == 2) check("cnt_three", 6'b010010, 1'b1, 2'b10, exp_cnt(entries));
      lamp_in   = 6'b001001;
      clr_fault = 1'b1;
      step();
    end
    check("cnt_saturated", 6'b001001, 1'b0, 2'b00, exp_cnt(entries));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
